// File: rtl/dpll_lock_ctrl_if.sv
// Control/status bundle between the DPLL lock controller and its environment.
// lossCount_o exists only when DPLL_LOCK_STATS_EN is defined.
interface dpll_lock_ctrl_if;
  logic       enable_i;
  logic [6:0] divFactor_i;
  logic       forwarding_i;
  logic       slowing_i;
  logic [6:0] divFactor_o;
  logic       bypass_o;
  logic       locked_o;
  logic [1:0] state_o;
  logic       lockLost_o;
`ifdef DPLL_LOCK_STATS_EN
  logic [7:0] lossCount_o;

  modport master (
    output enable_i, divFactor_i, forwarding_i, slowing_i,
    input  divFactor_o, bypass_o, locked_o, state_o, lockLost_o, lossCount_o
  );
  modport slave (
    input  enable_i, divFactor_i, forwarding_i, slowing_i,
    output divFactor_o, bypass_o, locked_o, state_o, lockLost_o, lossCount_o
  );
`else
  modport master (
    output enable_i, divFactor_i, forwarding_i, slowing_i,
    input  divFactor_o, bypass_o, locked_o, state_o, lockLost_o
  );
  modport slave (
    input  enable_i, divFactor_i, forwarding_i, slowing_i,
    output divFactor_o, bypass_o, locked_o, state_o, lockLost_o
  );
`endif
endinterface

// File: rtl/dpll_lock_ctrl.sv
// DPLL lock controller: window-based correction counting drives IDLE/ACQUIRE/TRACK/LOCKED.
// Optional loss statistics output enabled by macro DPLL_LOCK_STATS_EN.
module dpll_lock_ctrl #(
  parameter int WINDOW_LEN    = 64,
  parameter int LOCK_THRESH   = 2,
  parameter int LOCK_WINDOWS  = 4,
  parameter int UNLOCK_THRESH = 8
) (
  input logic            clk_i,
  input logic            reset_i,
  dpll_lock_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACQUIRE = 2'b01,
    TRACK   = 2'b10,
    LOCKED  = 2'b11
  } state_t;

  localparam logic [15:0] WIN_LAST    = 16'(WINDOW_LEN - 1);
  localparam logic [15:0] LOCK_LIM    = 16'(LOCK_THRESH);
  localparam logic [15:0] UNLOCK_LIM  = 16'(UNLOCK_THRESH);
  localparam logic [8:0]  QUIET_GOAL  = 9'(LOCK_WINDOWS);
  localparam logic [6:0]  DIV_DEFAULT = 7'd10;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic inc);
    if (inc && (v != 16'hFFFF)) return v + 16'd1;
    return v;
  endfunction

  state_t      state, state_nxt;
  logic [15:0] win_cnt, win_cnt_nxt;
  logic [15:0] corr_cnt, corr_cnt_nxt;
  logic [7:0]  quiet_cnt, quiet_cnt_nxt;
  logic [6:0]  div_q, div_nxt;
  logic        lock_lost_q, locked_q, bypass_q;
  logic        lost_nxt;
  logic        pulse, win_end, quiet_win;
  logic [15:0] eval_cnt;
  logic [8:0]  quiet_inc;

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    pulse     = bus.forwarding_i | bus.slowing_i;
    win_end   = (win_cnt == WIN_LAST);
    eval_cnt  = sat_inc16(corr_cnt, pulse);
    quiet_win = (eval_cnt <= LOCK_LIM);
    quiet_inc = {1'b0, quiet_cnt} + 9'd1;

    state_nxt     = state;
    quiet_cnt_nxt = quiet_cnt;
    div_nxt       = div_q;

    // Disable wins over any window-end decision made in the same cycle.
    if (!bus.enable_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.divFactor_i >= 7'd2) begin
            state_nxt = ACQUIRE;
            div_nxt   = bus.divFactor_i;
          end
        end
        ACQUIRE: if (win_end) state_nxt = TRACK;
        TRACK: begin
          if (win_end) begin
            if (quiet_win) begin
              quiet_cnt_nxt = quiet_inc[7:0];
              if (quiet_inc >= QUIET_GOAL) state_nxt = LOCKED;
            end else begin
              quiet_cnt_nxt = '0;
            end
          end
        end
        LOCKED: if (win_end && (eval_cnt >= UNLOCK_LIM)) state_nxt = TRACK;
        default: state_nxt = IDLE;
      endcase
    end

    if (state_nxt != TRACK) quiet_cnt_nxt = '0;
    lost_nxt = (state == LOCKED) && (state_nxt == TRACK);

    // A state change starts a fresh window; IDLE keeps both counters parked at zero.
    if ((state_nxt != state) || (state == IDLE) || win_end) begin
      win_cnt_nxt  = '0;
      corr_cnt_nxt = '0;
    end else begin
      win_cnt_nxt  = win_cnt + 16'd1;
      corr_cnt_nxt = eval_cnt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      win_cnt     <= '0;
      corr_cnt    <= '0;
      quiet_cnt   <= '0;
      div_q       <= DIV_DEFAULT;
      lock_lost_q <= 1'b0;
      locked_q    <= 1'b0;
      bypass_q    <= 1'b1;
    end else begin
      win_cnt     <= win_cnt_nxt;
      corr_cnt    <= corr_cnt_nxt;
      quiet_cnt   <= quiet_cnt_nxt;
      div_q       <= div_nxt;
      lock_lost_q <= lost_nxt;
      locked_q    <= (state_nxt == LOCKED);
      bypass_q    <= (state_nxt == IDLE);
    end
  end

  assign bus.state_o     = state;
  assign bus.divFactor_o = div_q;
  assign bus.lockLost_o  = lock_lost_q;
  assign bus.locked_o    = locked_q;
  assign bus.bypass_o    = bypass_q;

`ifdef DPLL_LOCK_STATS_EN
  logic [7:0] loss_cnt;

  always_ff @(posedge clk_i) begin
    if (reset_i)                          loss_cnt <= '0;
    else if (lost_nxt && loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
  end

  assign bus.lossCount_o = loss_cnt;
`endif

endmodule

// File: tb/tb_dpll_lock_ctrl.sv
// Self-checking bench for dpll_lock_ctrl: directed scenarios plus random traffic vs a window-level model.
module tb_dpll_lock_ctrl;
  localparam int WL = 64;
  localparam int LT = 2;
  localparam int LW = 4;
  localparam int UT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   lost_seen = 0;

  int m_state, m_pos, m_cnt, m_quiet, m_div, m_loss;
  bit m_lost;

  dpll_lock_ctrl_if bus ();

  dpll_lock_ctrl #(
    .WINDOW_LEN(WL), .LOCK_THRESH(LT), .LOCK_WINDOWS(LW), .UNLOCK_THRESH(UT)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model advances by one clock using the rules for windows, counts and states.
  task automatic step(input logic en, input logic [6:0] dv, input logic fw, input logic sl, input logic r);
    int  c, ns;
    bit  endw;
    rst = r;
    bus.enable_i = en;
    bus.divFactor_i = dv;
    bus.forwarding_i = fw;
    bus.slowing_i = sl;
    if (r) begin
      m_state = 0; m_pos = 0; m_cnt = 0; m_quiet = 0; m_div = 10; m_lost = 0; m_loss = 0;
    end else begin
      endw = (m_pos == WL - 1);
      c = m_cnt + ((fw || sl) ? 1 : 0);
      if (c > 65535) c = 65535;
      ns = m_state;
      m_lost = 0;
      if (!en) ns = 0;
      else if (m_state == 0) begin
        if (dv >= 2) begin ns = 1; m_div = dv; end
      end else if (m_state == 1) begin
        if (endw) ns = 2;
      end else if (m_state == 2) begin
        if (endw) begin
          if (c <= LT) begin
            m_quiet++;
            if (m_quiet >= LW) ns = 3;
          end else m_quiet = 0;
        end
      end else if (endw && c >= UT) begin
        ns = 2; m_lost = 1;
        if (m_loss < 255) m_loss++;
      end
      if (ns != 2) m_quiet = 0;
      if (ns != m_state || ns == 0 || endw) begin m_pos = 0; m_cnt = 0; end
      else begin m_pos++; m_cnt = c; end
      m_state = ns;
    end
    @(posedge clk);
    #1;
    if (bus.lockLost_o === 1'b1) lost_seen++;
    chk("state", 16'(bus.state_o), 16'(m_state));
    chk("locked", 16'(bus.locked_o), 16'(m_state == 3));
    chk("bypass", 16'(bus.bypass_o), 16'(m_state == 0));
    chk("lockLost", 16'(bus.lockLost_o), 16'(m_lost));
    chk("divFactor", 16'(bus.divFactor_o), 16'(m_div));
`ifdef DPLL_LOCK_STATS_EN
    chk("lossCount", 16'(bus.lossCount_o), 16'(m_loss));
`endif
  endtask

  task automatic run_window(input int n, input bit both, input logic en_last);
    for (int i = 0; i < WL; i++)
      step((i == WL - 1) ? en_last : 1'b1, 7'd10, (i < n), both && (i < n), 1'b0);
  endtask

  task automatic run_to_lock();
    step(1'b1, 7'd10, 1'b0, 1'b0, 1'b0);
    chk("acquire_entry", 16'(bus.state_o), 16'd1);
    for (int i = 0; i < WL; i++) step(1'b1, 7'($urandom_range(0, 127)), 1'b0, 1'b0, 1'b0);
    chk("track_entry", 16'(bus.state_o), 16'd2);
    for (int i = 0; i < LW * WL; i++) step(1'b1, 7'($urandom_range(0, 127)), 1'b0, 1'b0, 1'b0);
    chk("lock_reached", 16'(bus.locked_o), 16'd1);
    chk("lock_div", 16'(bus.divFactor_o), 16'd10);
  endtask

  initial begin
    int burst;
    logic fw, sl, en, r;
    logic [6:0] dv;
    bus.enable_i = 1'b0;
    bus.divFactor_i = 7'd0;
    bus.forwarding_i = 1'b0;
    bus.slowing_i = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b1, 7'd10, 1'b1, 1'b0, 1'b1);
    chk("reset_div", 16'(bus.divFactor_o), 16'd10);
    chk("reset_bypass", 16'(bus.bypass_o), 16'd1);

    for (int i = 0; i < 200; i++) step(1'b1, 7'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 7'd0, 1'b1, 1'b0, 1'b0);
    chk("div_low_idle", 16'(bus.state_o), 16'd0);
    chk("div_low_bypass", 16'(bus.bypass_o), 16'd1);

    run_to_lock();

    for (int k = 0; k < WL && m_pos != 0; k++) step(1'b1, 7'd10, 1'b0, 1'b0, 1'b0);
    lost_seen = 0;
    run_window(8, 1'b0, 1'b1);
    chk("unlock_to_track", 16'(bus.state_o), 16'd2);
`ifdef DPLL_LOCK_STATS_EN
    chk("loss_one", 16'(bus.lossCount_o), 16'd1);
`endif

    run_window(2, 1'b1, 1'b1);
    run_window(3, 1'b1, 1'b1);
    for (int w = 0; w < 3; w++) run_window(0, 1'b0, 1'b1);
    chk("relock_pending", 16'(bus.state_o), 16'd2);
    run_window(0, 1'b0, 1'b1);
    chk("relock", 16'(bus.state_o), 16'd3);
    chk("lost_once", 16'(lost_seen), 16'd1);

    run_window(8, 1'b0, 1'b1);
    for (int w = 0; w < 3; w++) run_window(0, 1'b0, 1'b1);
    run_window(0, 1'b0, 1'b0);
    chk("disable_beats_lock", 16'(bus.state_o), 16'd0);
    chk("disable_not_locked", 16'(bus.locked_o), 16'd0);

    run_to_lock();
    step(1'b1, 7'd10, 1'b1, 1'b1, 1'b1);
    chk("rst_locked_idle", 16'(bus.state_o), 16'd0);
    chk("rst_locked_nolost", 16'(bus.lockLost_o), 16'd0);
    chk("rst_locked_div", 16'(bus.divFactor_o), 16'd10);

    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      if (burst == 0 && $urandom_range(0, 299) == 0) burst = $urandom_range(4, 12);
      fw = (burst > 0) || ($urandom_range(0, 49) == 0);
      sl = ($urandom_range(0, 59) == 0);
      if (burst > 0) burst--;
      en = ($urandom_range(0, 399) != 0);
      r  = ($urandom_range(0, 999) == 0);
      dv = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 2)) : 7'($urandom_range(0, 127));
      step(en, dv, fw, sl, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
